demorgan_seq_checker: RTL and testbench

Self-checking sequencer for the two-input De Morgan gate datapath. On a start pulse it drives each of the four input vectors (A,B) = 00, 01, 10, 11 onto the datapath and waits a programmable settle time. It then samples the six datapath outputs and checks them against both De Morgan identities and the inverter outputs. It reports a per-vector fail mask, a failing-vector count and a pass flag, so the datapath can be verified in-system instead of by reading a printed truth table.

---
 rtl/demorgan_seq_checker_if.sv | 29 ++
 rtl/demorgan_seq_checker.sv | 131 +++++++++++++
 tb/tb_demorgan_seq_checker.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demorgan_seq_checker_if.sv
// Bundle between the De Morgan sequencer/checker and the gate datapath it exercises.
// master = checker side (drives vectors, reports results); slave = datapath/host side.
interface demorgan_seq_checker_if;
    logic       start;
    logic       A;
    logic       B;
    logic       nA;
    logic       nB;
    logic       nAandnB;
    logic       nAorB;
    logic       nAornB;
    logic       nAandB;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_mask;
    logic [1:0] vec_idx;

    modport master (
        input  start, nA, nB, nAandnB, nAorB, nAornB, nAandB,
        output A, B, busy, done, pass, err_count, fail_mask, vec_idx
    );

    modport slave (
        output start, nA, nB, nAandnB, nAorB, nAornB, nAandB,
        input  A, B, busy, done, pass, err_count, fail_mask, vec_idx
    );
endinterface

// File: rtl/demorgan_seq_checker.sv
// Walks (A,B) through 00,01,10,11, waits SETTLE cycles per vector, then checks the six
// datapath outputs against the inverter and De Morgan identities and reports the result.
module demorgan_seq_checker #(
    parameter int unsigned SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    demorgan_seq_checker_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    localparam logic [3:0] LP_RELOAD = 4'(SETTLE - 1);

    function automatic logic vector_ok(
        input logic a, input logic b,
        input logic na, input logic nb,
        input logic n_and_n, input logic n_or,
        input logic n_or_n, input logic n_and
    );
        return (na == ~a) && (nb == ~b) &&
               (n_or == ~(a | b)) && (n_and == ~(a & b)) &&
               (n_and_n == n_or) && (n_or_n == n_and);
    endfunction

    // Count is bounded by the four vectors; saturate so it can never wrap.
    function automatic logic [2:0] sat_inc(input logic [2:0] v);
        return (v >= 3'd4) ? 3'd4 : v + 3'd1;
    endfunction

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_a;
    logic       r_b;
    logic [1:0] r_vec_idx;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err_count;
    logic [3:0] r_fail_mask;

    logic       w_vec_fail;
    logic [2:0] w_err_next;
    logic [3:0] w_mask_next;
    logic [1:0] w_vec_plus;

    assign w_vec_fail  = !vector_ok(r_a, r_b, bus.nA, bus.nB, bus.nAandnB,
                                    bus.nAorB, bus.nAornB, bus.nAandB);
    assign w_err_next  = w_vec_fail ? sat_inc(r_err_count) : r_err_count;
    assign w_mask_next = r_fail_mask | (w_vec_fail ? (4'b0001 << r_vec_idx) : 4'b0000);
    assign w_vec_plus  = r_vec_idx + 2'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_a         <= 1'b0;
            r_b         <= 1'b0;
            r_vec_idx   <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_err_count <= 3'd0;
            r_fail_mask <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_err_count <= 3'd0;
                        r_fail_mask <= 4'd0;
                        r_pass      <= 1'b0;
                        r_vec_idx   <= 2'd0;
                        r_a         <= 1'b0;
                        r_b         <= 1'b0;
                        r_cnt       <= LP_RELOAD;
                        r_busy      <= 1'b1;
                        r_state     <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_CHECK;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_CHECK: begin
                    r_err_count <= w_err_next;
                    r_fail_mask <= w_mask_next;
                    if (r_vec_idx == 2'd3) begin
                        // pass must reflect the final vector, so use the updated count.
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_next == 3'd0);
                        r_state <= S_DONE;
                    end else begin
                        r_vec_idx    <= w_vec_plus;
                        {r_a, r_b}   <= w_vec_plus;
                        r_cnt        <= LP_RELOAD;
                        r_state      <= S_SETTLE;
                    end
                end
                S_DONE: begin
                    r_done    <= 1'b0;
                    r_a       <= 1'b0;
                    r_b       <= 1'b0;
                    r_vec_idx <= 2'd0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.A         = r_a;
    assign bus.B         = r_b;
    assign bus.vec_idx   = r_vec_idx;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_count;
    assign bus.fail_mask = r_fail_mask;

endmodule

// File: tb/tb_demorgan_seq_checker.sv
// Directed bench for demorgan_seq_checker: two instances (SETTLE=1 and SETTLE=3) each
// driving a behavioural De Morgan datapath with selectable faults and output delay.
module tb_demorgan_seq_checker;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    demorgan_seq_checker_if bus1 ();
    demorgan_seq_checker_if bus3 ();

    demorgan_seq_checker #(.SETTLE(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    demorgan_seq_checker #(.SETTLE(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    // mode: 0 ideal, 1 nAandB stuck 0, 2 nA stuck 1, 3 two-cycle output delay
    int   mode;
    int   n_checks;
    int   n_fail;
    logic d1a, d1b, d2a, d2b;
    logic e1a, e1b, e2a, e2b;
    logic m1a, m1b, m3a, m3b;

    always @(posedge clk) begin
        d1a <= bus1.A;  d1b <= bus1.B;  d2a <= d1a;  d2b <= d1b;
        e1a <= bus3.A;  e1b <= bus3.B;  e2a <= e1a;  e2b <= e1b;
    end

    always_comb begin
        m1a = (mode == 3) ? d2a : bus1.A;
        m1b = (mode == 3) ? d2b : bus1.B;
        bus1.nA      = (mode == 2) ? 1'b1 : ~m1a;
        bus1.nB      = ~m1b;
        bus1.nAorB   = ~(m1a | m1b);
        bus1.nAandB  = (mode == 1) ? 1'b0 : ~(m1a & m1b);
        bus1.nAandnB = ~m1a & ~m1b;
        bus1.nAornB  = ~m1a | ~m1b;
    end

    always_comb begin
        m3a = e2a;
        m3b = e2b;
        bus3.nA      = ~m3a;
        bus3.nB      = ~m3b;
        bus3.nAorB   = ~(m3a | m3b);
        bus3.nAandB  = ~(m3a & m3b);
        bus3.nAandnB = ~m3a & ~m3b;
        bus3.nAornB  = ~m3a | ~m3b;
    end

    task automatic do_run(input int sel, input int exp_cycles, input logic [3:0] exp_mask,
                          input logic [2:0] exp_err, input logic exp_pass, input string name);
        int   n;
        logic got;
        logic [3:0] mask;
        logic [2:0] err;
        logic pass_v, done_v, busy_v;
        @(negedge clk);
        if (sel == 1) bus1.start = 1'b1; else bus3.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        bus3.start = 1'b0;
        n   = 1;
        got = 1'b0;
        while (n < 60 && !got) begin
            done_v = (sel == 1) ? bus1.done : bus3.done;
            if (done_v) got = 1'b1;
            else begin
                @(negedge clk);
                n++;
            end
        end
        mask   = (sel == 1) ? bus1.fail_mask : bus3.fail_mask;
        err    = (sel == 1) ? bus1.err_count : bus3.err_count;
        pass_v = (sel == 1) ? bus1.pass : bus3.pass;
        n_checks++;
        if (got !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_done_timeout: no done within %0d cycles, required done", name, n);
        end
        n_checks++;
        if (n !== exp_cycles) begin
            n_fail++;
            $display("FAIL %s_done_cycle: got %0d required %0d", name, n, exp_cycles);
        end
        n_checks++;
        if ({mask, err, pass_v} !== {exp_mask, exp_err, exp_pass}) begin
            n_fail++;
            $display("FAIL %s_result: mask=%b err=%0d pass=%b required mask=%b err=%0d pass=%b",
                     name, mask, err, pass_v, exp_mask, exp_err, exp_pass);
        end
        @(negedge clk);
        done_v = (sel == 1) ? bus1.done : bus3.done;
        busy_v = (sel == 1) ? bus1.busy : bus3.busy;
        n_checks++;
        if ({done_v, busy_v} !== 2'b00) begin
            n_fail++;
            $display("FAIL %s_after_done: done,busy=%b required 00", name, {done_v, busy_v});
        end
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        bus1.start = 1'b0;
        bus3.start = 1'b0;
        mode       = 0;
        repeat (4) @(negedge clk);
        n_checks++;
        if ({bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass, bus1.err_count, bus1.fail_mask,
             bus1.vec_idx} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_dut1: A=%b B=%b busy=%b done=%b pass=%b err=%0d mask=%b vec=%0d required all 0",
                     bus1.A, bus1.B, bus1.busy, bus1.done, bus1.pass, bus1.err_count,
                     bus1.fail_mask, bus1.vec_idx);
        end
        n_checks++;
        if ({bus3.A, bus3.B, bus3.busy, bus3.done, bus3.pass, bus3.err_count, bus3.fail_mask,
             bus3.vec_idx} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_dut3: outputs=%b required all 0",
                     {bus3.A, bus3.B, bus3.busy, bus3.done, bus3.pass, bus3.err_count,
                      bus3.fail_mask, bus3.vec_idx});
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus1.busy, bus1.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_hold: busy,done=%b required 00", {bus1.busy, bus1.done});
        end
    endtask

    task automatic test_ideal();
        logic [1:0] v;
        mode = 0;
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            v = 2'((c - 1) / 2);
            n_checks++;
            if ({bus1.busy, bus1.done, bus1.A, bus1.B, bus1.vec_idx} !== {2'b10, v, v}) begin
                n_fail++;
                $display("FAIL ideal_cycle%0d: busy=%b done=%b AB=%b%b vec=%0d required busy=1 done=0 AB=%b vec=%0d",
                         c, bus1.busy, bus1.done, bus1.A, bus1.B, bus1.vec_idx, v, v);
            end
            @(negedge clk);
        end
        n_checks++;
        if ({bus1.done, bus1.busy, bus1.pass, bus1.err_count, bus1.fail_mask, bus1.A, bus1.B}
            !== {3'b101, 3'd0, 4'b0000, 2'b11}) begin
            n_fail++;
            $display("FAIL ideal_done: done=%b busy=%b pass=%b err=%0d mask=%b AB=%b%b required 1 0 1 0 0000 11",
                     bus1.done, bus1.busy, bus1.pass, bus1.err_count, bus1.fail_mask, bus1.A, bus1.B);
        end
        @(negedge clk);
        n_checks++;
        if ({bus1.done, bus1.busy, bus1.pass, bus1.A, bus1.B, bus1.vec_idx} !== 7'b0010000) begin
            n_fail++;
            $display("FAIL ideal_idle: done=%b busy=%b pass=%b AB=%b%b vec=%0d required 0 0 1 00 0",
                     bus1.done, bus1.busy, bus1.pass, bus1.A, bus1.B, bus1.vec_idx);
        end
    endtask

    task automatic test_fault_nand();
        mode = 1;
        do_run(1, 9, 4'b0111, 3'd3, 1'b0, "nand_stuck0");
    endtask

    task automatic test_fault_na();
        mode = 2;
        do_run(1, 9, 4'b1100, 3'd2, 1'b0, "na_stuck1");
        mode = 0;
        do_run(1, 9, 4'b0000, 3'd0, 1'b1, "rerun_cleared");
    endtask

    task automatic test_start_held();
        int ndone;
        int n;
        mode  = 0;
        ndone = 0;
        @(negedge clk);
        bus1.start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus1.done) ndone++;
        end
        n_checks++;
        if (ndone !== 1) begin
            n_fail++;
            $display("FAIL held_done_count: got %0d pulses required 1", ndone);
        end
        n_checks++;
        if (bus1.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL held_idle_gap: busy=%b required 0", bus1.busy);
        end
        @(negedge clk);
        bus1.start = 1'b0;
        n_checks++;
        if (bus1.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL held_restart: busy=%b required 1", bus1.busy);
        end
        n = 0;
        while (n < 40 && !bus1.done) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (bus1.done !== 1'b1) begin
            n_fail++;
            $display("FAIL held_second_run: done=%b required 1", bus1.done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int ndone;
        mode = 0;
        @(negedge clk);
        bus1.start = 1'b1;
        @(negedge clk);
        bus1.start = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus1.busy, bus1.A, bus1.B} !== 3'b101) begin
            n_fail++;
            $display("FAIL midrun_before: busy,A,B=%b required 101", {bus1.busy, bus1.A, bus1.B});
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus1.A, bus1.B, bus1.busy, bus1.done, bus1.err_count, bus1.vec_idx} !== 9'd0) begin
            n_fail++;
            $display("FAIL midrun_async_reset: A=%b B=%b busy=%b done=%b err=%0d vec=%0d required all 0",
                     bus1.A, bus1.B, bus1.busy, bus1.done, bus1.err_count, bus1.vec_idx);
        end
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (bus1.done || bus1.busy) ndone++;
        end
        n_checks++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL midrun_no_done: %0d cycles with done/busy after abort, required 0", ndone);
        end
        do_run(1, 9, 4'b0000, 3'd0, 1'b1, "after_abort");
    endtask

    task automatic test_delay();
        do_run(3, 17, 4'b0000, 3'd0, 1'b1, "delay_settle3");
        mode = 3;
        repeat (3) @(negedge clk);
        do_run(1, 9, 4'b1110, 3'd3, 1'b0, "delay_settle1");
        mode = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_ideal();
        test_fault_nand();
        test_fault_na();
        test_start_held();
        test_reset_mid();
        test_delay();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required bench completion");
        $fatal(1, "watchdog");
    end

endmodule
